// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_N     = 4;

  function automatic logic [FLAG_N-1:0] pack_flags(input logic c, input logic z,
                                                   input logic o, input logic n);
    logic [FLAG_N-1:0] f;
    f = 4'b0000;
    f[FLAG_CARRY] = c;
    f[FLAG_ZERO]  = z;
    f[FLAG_OVF]   = o;
    f[FLAG_NEG]   = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial-product step per clock,
// CYCLES steps per product, done pulses for one cycle with the final product.
module alu_seq_mul #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               en,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // Load on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      mcand   <= {(2*WIDTH){1'b0}};
      mplier  <= {WIDTH{1'b0}};
      cnt     <= {CW{1'b0}};
      product <= {(2*WIDTH){1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
        cnt     <= CW'(CYCLES);
        product <= {(2*WIDTH){1'b0}};
        busy    <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          product <= product + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with an iterative multiplier.
// Optional accumulator operand: define ALU_SEQ_ACC_EN.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         s,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               carry,
  output logic               zero,
  output logic               ovf,
  output logic               neg,
  input  logic               acc_sel
);
  import alu_seq_pkg::*;

  localparam int MUL_EN_CYCLES = WIDTH;
  localparam int SHAMT_W       = $clog2(WIDTH);

  state_e             state;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [FLAG_N-1:0]  flags;
  logic [WIDTH-1:0]   a_eff;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [FLAG_N-1:0]  mul_flags;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [WIDTH:0]       shl_ext;
  logic [WIDTH:0]       shr_ext;
  logic [SHAMT_W-1:0]   amt;
  logic [2*WIDTH-1:0]   alu_y;
  logic                 alu_c;
  logic                 alu_o;
  logic [FLAG_N-1:0]    alu_flags;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (s == OP_MUL);

`ifdef ALU_SEQ_ACC_EN
  logic [WIDTH-1:0] acc;

  // Accumulator follows the low half of every result the consumer takes.
  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      acc <= {WIDTH{1'b0}};
    end else if (out_valid && out_ready) begin
      acc <= y[WIDTH-1:0];
    end
  end

  assign a_eff = acc_sel ? acc : a;
`else
  logic unused_acc_sel;
  assign unused_acc_sel = acc_sel;
  assign a_eff          = a;
`endif

  // The multiplier takes operands straight from the ports on the accept edge.
  alu_seq_mul #(
    .WIDTH  (WIDTH),
    .CYCLES (MUL_EN_CYCLES)
  ) u_mul (
    .clk     (clk),
    .en      (en),
    .start   (mul_start),
    .a       (a_eff),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign mul_flags = pack_flags(1'b0, mul_prod == {(2*WIDTH){1'b0}},
                                |mul_prod[2*WIDTH-1:WIDTH], mul_prod[2*WIDTH-1]);

  // Single-cycle datapath for ops 0-6 on the captured operands.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    amt     = b_q[SHAMT_W-1:0];
    shl_ext = {1'b0, a_q} << amt;
    shr_ext = {a_q, 1'b0} >> amt;
    alu_y   = {(2*WIDTH){1'b0}};
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_y = {{(WIDTH-1){1'b0}}, sum};
        alu_c = sum[WIDTH];
        alu_o = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y = {{(WIDTH-1){1'b0}}, diff};
        alu_c = diff[WIDTH];
        alu_o = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_y = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:  alu_y = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR: alu_y = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_SHL: begin
        alu_y = {{WIDTH{1'b0}}, shl_ext[WIDTH-1:0]};
        alu_c = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_y = {{WIDTH{1'b0}}, shr_ext[WIDTH:1]};
        alu_c = shr_ext[0];
      end
      default: begin
        alu_y = {(2*WIDTH){1'b0}};
        alu_c = 1'b0;
        alu_o = 1'b0;
      end
    endcase
    alu_flags = pack_flags(alu_c, alu_y == {(2*WIDTH){1'b0}}, alu_o, alu_y[WIDTH-1]);
  end

  // Control FSM; in_ready, out_valid, y and flags are all registered here.
  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      y         <= {(2*WIDTH){1'b0}};
      flags     <= {FLAG_N{1'b0}};
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q      <= a_eff;
            b_q      <= b;
            op_q     <= op_e'(s);
            in_ready <= 1'b0;
            state    <= (s == OP_MUL) ? ST_MUL : ST_EXEC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          y         <= alu_y;
          flags     <= alu_flags;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_MUL: begin
          if (mul_done) begin
            y         <= mul_prod;
            flags     <= mul_flags;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (!mul_busy) begin
            // Multiplier lost its job without finishing: recover to idle.
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign carry = flags[FLAG_CARRY];
  assign zero  = flags[FLAG_ZERO];
  assign ovf   = flags[FLAG_OVF];
  assign neg   = flags[FLAG_NEG];

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at WIDTH=8, plus hold, reset-abort
// and (when ALU_SEQ_ACC_EN is defined) accumulator sequences.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        en;
  logic [7:0]  a, b;
  logic [2:0]  s;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] y;
  logic        carry, zero, ovf, neg, acc_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
    logic [3:0]  f;   // {carry, zero, ovf, neg}
    int          lat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .en(en), .a(a), .b(b), .s(s),
    .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .carry(carry), .zero(zero), .ovf(ovf), .neg(neg),
    .acc_sel(acc_sel)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] aa, input logic [7:0] bb, input logic [2:0] ss,
                       input logic sel);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready wait timeout", {31'd0, in_ready}, 32'd1);
    a = aa; b = bb; s = ss; acc_sel = sel; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_sel  = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic ready_hi);
    lat = 0;
    ready_hi = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_hi = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic complete(input string tag);
    check({tag, " in_ready low in done"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid dropped"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    logic        rh;
    logic        seen;
    string       tag;

    //             s     a      b      y         {c,z,o,n} lat
    vecs[0]  = '{3'd0, 8'hFF, 8'h01, 16'h0100, 4'b1000, 1};
    vecs[1]  = '{3'd1, 8'h80, 8'h01, 16'h007F, 4'b0010, 1};
    vecs[2]  = '{3'd0, 8'h7F, 8'h01, 16'h0080, 4'b0011, 1};
    vecs[3]  = '{3'd1, 8'h03, 8'h05, 16'h01FE, 4'b1001, 1};
    vecs[4]  = '{3'd2, 8'hF0, 8'h3C, 16'h0030, 4'b0000, 1};
    vecs[5]  = '{3'd3, 8'h00, 8'h00, 16'h0000, 4'b0100, 1};
    vecs[6]  = '{3'd4, 8'hA5, 8'h5A, 16'h00FF, 4'b0001, 1};
    vecs[7]  = '{3'd5, 8'h81, 8'h01, 16'h0002, 4'b1000, 1};
    vecs[8]  = '{3'd5, 8'h01, 8'h08, 16'h0001, 4'b0000, 1};
    vecs[9]  = '{3'd6, 8'h81, 8'h01, 16'h0040, 4'b1000, 1};
    vecs[10] = '{3'd6, 8'h80, 8'h0F, 16'h0001, 4'b0000, 1};
    vecs[11] = '{3'd7, 8'hFF, 8'hFF, 16'hFE01, 4'b0011, 9};
    vecs[12] = '{3'd7, 8'h00, 8'h37, 16'h0000, 4'b0100, 9};
    vecs[13] = '{3'd7, 8'h0F, 8'h03, 16'h002D, 4'b0000, 9};
    vecs[14] = '{3'd1, 8'h05, 8'h05, 16'h0000, 4'b0100, 1};

    a = 8'h00; b = 8'h00; s = 3'd0; in_valid = 1'b0; out_ready = 1'b0; acc_sel = 1'b0;
    en = 1'b1;
    #1 en = 1'b0;
    #1;
    check("reset y", {16'd0, y}, 32'd0);
    check("reset out_valid/flags", {27'd0, out_valid, carry, zero, ovf, neg}, 32'd0);
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready after reset", {31'd0, in_ready}, 32'd1);
    check("out_valid after reset", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      tag = $sformatf("vec%0d op%0d", i, vecs[i].s);
      issue(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0);
      wait_result(lat, rh);
      check({tag, " latency"}, lat, vecs[i].lat);
      check({tag, " in_ready during exec"}, {31'd0, rh}, 32'd0);
      check({tag, " y"}, {16'd0, y}, {16'd0, vecs[i].y});
      check({tag, " flags czon"}, {28'd0, carry, zero, ovf, neg}, {28'd0, vecs[i].f});
      complete(tag);
    end

    // Result held under back-pressure while in_valid pulses are ignored.
    issue(8'h12, 8'h34, 3'd0, 1'b0);
    wait_result(lat, rh);
    check("hold first y", {16'd0, y}, 32'h46);
    for (int i = 0; i < 5; i++) begin
      a = 8'(i * 37 + 1); b = 8'(i * 11 + 2); s = 3'(i + 3); in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("hold%0d y", i), {16'd0, y}, 32'h46);
      check($sformatf("hold%0d ov/ir/flags", i),
            {26'd0, out_valid, in_ready, carry, zero, ovf, neg}, 32'b10_0000);
    end
    in_valid = 1'b0;
    complete("hold");
    issue(8'h01, 8'h01, 3'd0, 1'b0);
    wait_result(lat, rh);
    check("after hold y", {16'd0, y}, 32'h2);
    complete("after hold");

    // Reset in the middle of a multiply must abort it silently.
    issue(8'hFF, 8'hFF, 3'd7, 1'b0);
    repeat (4) @(negedge clk);
    en = 1'b0;
    #1;
    check("abort y", {16'd0, y}, 32'd0);
    check("abort ov/ir/flags", {26'd0, out_valid, in_ready, carry, zero, ovf, neg}, 32'd0);
    repeat (2) @(negedge clk);
    en = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no result after abort", {31'd0, seen}, 32'd0);
    issue(8'h03, 8'h04, 3'd0, 1'b0);
    wait_result(lat, rh);
    check("post-abort add latency", lat, 1);
    check("post-abort add y", {16'd0, y}, 32'h7);
    complete("post-abort");

`ifdef ALU_SEQ_ACC_EN
    issue(8'h05, 8'h03, 3'd0, 1'b0);
    wait_result(lat, rh);
    check("acc seed y", {16'd0, y}, 32'h8);
    complete("acc seed");
    issue(8'hEE, 8'h02, 3'd0, 1'b1);
    wait_result(lat, rh);
    check("acc add y", {16'd0, y}, 32'hA);
    complete("acc add");
`else
    issue(8'h11, 8'h01, 3'd0, 1'b1);
    wait_result(lat, rh);
    check("acc_sel ignored y", {16'd0, y}, 32'h12);
    complete("acc_sel ignored");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width (range 2..32).
REQ-002 SHALL have parameter MUL_EN_CYCLES, default WIDTH, multiplier iteration count (fixed equal to WIDTH; not overridable).
REQ-003 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- en  in  1  reset, asynchronous, active-low.
- a, b  in  WIDTH  operands.
- s  in  3  operation select.
- in_valid  in  1  operands/op offered.
- in_ready  out  1  block can accept.
- y  out  2*WIDTH  result.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- carry, zero, ovf, neg  out  1 each  status flags.
- acc_sel  in  1  use accumulator as operand a (only with ALU_SEQ_ACC_EN).

Function
REQ-004 SHALL capture a, b, s (and acc_sel) into internal registers only on the cycle where in_valid && in_ready.
REQ-005 SHALL implement s: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SHL (a<<b[log2 WIDTH-1:0]), 6 SHR logical, 7 MUL unsigned.
REQ-006 SHALL zero-extend results of ops 0-6 to 2*WIDTH; y[WIDTH] = carry-out for ADD, borrow for SUB, 0 otherwise.
REQ-007 SHALL produce MUL as the full 2*WIDTH-bit product.
REQ-008 SHALL run FSM IDLE -> EXEC -> DONE for ops 0-6, and IDLE -> MUL -> DONE for op 7.
REQ-009 SHALL stay in MUL for exactly WIDTH cycles (one shift-add step per cycle).
REQ-010 SHALL assert out_valid on the cycle after an accept for ops 0-6, and WIDTH+1 cycles after the accept for MUL.
REQ-011 SHALL assert in_ready only in IDLE.
REQ-012 SHALL hold y, out_valid and flags stable in DONE until out_ready is high, then return to IDLE; in_ready rises the following cycle.
REQ-013 SHALL set carry to the ADD carry-out, SUB borrow, or last bit shifted out for SHL/SHR, and clear it for the logic ops and MUL.
REQ-014 SHALL set ovf on signed two's-complement overflow for ADD/SUB, and for MUL when product[2*WIDTH-1:WIDTH] != 0; otherwise ovf = 0.
REQ-015 SHALL set zero when y == 0 (full 2*WIDTH bits), and neg = y[WIDTH-1] for ops 0-6 and y[2*WIDTH-1] for MUL.
REQ-016 SHALL ignore in_valid while not in IDLE; the operand registers SHALL NOT change.
REQ-017 SHALL produce MUL by 0 as y = 0 with zero = 1, and SHL/SHR by an amount >= WIDTH under the masked-amount rule of REQ-005.

Reset
REQ-018 SHALL, on en low, immediately force the FSM to IDLE, clear the operand registers and clear y, carry, zero, ovf, neg, out_valid and the accumulator; in_ready = 1 once en is high.
REQ-019 SHALL abort any MUL or DONE in progress on reset, with no result emitted afterwards.

Configuration
REQ-020 SHALL support macro ALU_SEQ_ACC_EN.
- Defined: an accumulator register (WIDTH bits) loads y[WIDTH-1:0] on each out handshake; when acc_sel = 1 at accept, the accumulator replaces a.
- Undefined: the acc_sel port SHALL still exist but be ignored, and no accumulator register is built.

Structure
REQ-021 SHALL place the op encoding enum, the FSM state enum and the flag bit indices in package alu_seq_pkg.
REQ-022 SHALL implement the iterative shift-add multiplier as sub-module alu_seq_mul (start, busy/done, WIDTH parameter).

Verification
REQ-023 SHALL cover: WIDTH=8, ADD 0xFF+0x01 -> y=0x0100, carry=1, zero=0 (low byte 0 but y≠0), ovf=0, out_valid 1 cycle after accept.
REQ-024 SHALL cover: SUB 0x80-0x01 -> y=0x007F, ovf=1, carry=0, neg=0.
REQ-025 SHALL cover: MUL 0xFF*0xFF -> y=0xFE01, ovf=1, out_valid exactly 9 cycles after accept; in_ready=0 throughout.
REQ-026 SHALL cover: result held with out_ready=0 for 5 cycles -> y/flags stable; in_valid pulses ignored; in_ready rises 1 cycle after out_ready.
REQ-027 SHALL cover: en driven low mid-MUL -> all outputs 0 asynchronously, no out_valid afterwards, next ADD 3+4 -> y=7.
REQ-028 SHALL cover, with ALU_SEQ_ACC_EN: ADD 5+3, then acc_sel=1 ADD b=2 -> y=0x000A.
